// File: rtl/sseg_digit_scanner.sv
// Scan stage for a 4-digit seven-segment display: walks the four hex nibbles of a
// double-buffered 16-bit value, driving one active-low anode per slot with optional leading-zero blanking.
module sseg_digit_scanner #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LD,
  input  logic [15:0] DATA,
  input  logic        BLANK_EN,
  output logic [3:0]  BIN,
  output logic [3:0]  AN,
  output logic        FRAME
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   pend;
  logic          pflag;
  logic          tick;
  logic          wrap;
  logic          blank;

  assign tick = (presc == PMAX);
  assign wrap = tick && (idx == 2'd3);

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
      idx   <= '0;
      disp  <= '0;
      pend  <= '0;
      pflag <= 1'b0;
    end else begin
      if (tick) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end

      if (LD) begin
        pend  <= DATA;
        pflag <= 1'b1;
      end

      // A load landing on the wrap edge bypasses pend and commits directly.
      if (wrap) begin
        if (LD) begin
          disp  <= DATA;
          pflag <= 1'b0;
        end else if (pflag) begin
          disp  <= pend;
          pflag <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (disp[15:4]  == 12'h000);
      2'd2:    blank = (disp[15:8]  == 8'h00);
      2'd3:    blank = (disp[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end

  always_comb begin
    BIN   = disp[{idx, 2'b00} +: 4];
    AN    = '1;
    if (!(BLANK_EN && blank)) AN[idx] = 1'b0;
    FRAME = wrap;
  end

endmodule

// File: tb/tb_sseg_digit_scanner.sv
// Directed bench for sseg_digit_scanner: vector table for scan/load/commit,
// hand sequences for blanking, mid-frame reset and slot/frame length.
module tb_sseg_digit_scanner;

  logic        clk = 1'b0;
  logic        rst, ld, blank_en;
  logic [15:0] data;
  logic [3:0]  bin, an;
  logic        frame;

  logic        rst2;
  logic [3:0]  bin2, an2;
  logic        frame2;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sseg_digit_scanner #(.SCAN_DIV(4)) dut (
    .CLK(clk), .RST(rst), .LD(ld), .DATA(data), .BLANK_EN(blank_en),
    .BIN(bin), .AN(an), .FRAME(frame)
  );

  sseg_digit_scanner #(.SCAN_DIV(1000)) dut_big (
    .CLK(clk), .RST(rst2), .LD(1'b0), .DATA(16'h0000), .BLANK_EN(1'b0),
    .BIN(bin2), .AN(an2), .FRAME(frame2)
  );

  typedef struct {
    logic        ld;
    logic [15:0] data;
    logic [3:0]  bin;
    logic [3:0]  an;
    logic        frame;
  } vec_t;

  vec_t tv[48];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] v1;
    logic [3:0]  an_b  [4];
    logic [3:0]  bin_b [4];
    logic [3:0]  an_z  [4];
    int unsigned cnt;
    int unsigned s;

    v1 = 16'hA3C5;
    for (int k = 0; k < 48; k++) begin
      s = (k / 4) % 4;
      tv[k].ld    = 1'b0;
      tv[k].data  = 16'h0000;
      tv[k].an    = ~(4'b0001 << s);
      tv[k].frame = ((k % 16) == 15);
      if (k < 16)      tv[k].bin = 4'h0;
      else if (k < 32) tv[k].bin = v1[4*s +: 4];
      else             tv[k].bin = 4'h2;
    end
    tv[5].ld  = 1'b1; tv[5].data  = 16'hA3C5;
    tv[17].ld = 1'b1; tv[17].data = 16'h1111;
    tv[31].ld = 1'b1; tv[31].data = 16'h2222;

    an_b  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    bin_b = '{4'h0, 4'h4, 4'h0, 4'h0};
    an_z  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};

    rst = 1'b1; rst2 = 1'b1; ld = 1'b0; data = 16'h0000; blank_en = 1'b0;

    // Reset state, then the scan/load/overwrite table.
    step(2);
    chk("rst_bin", bin, 4'h0);
    chk("rst_an", an, 4'b1110);
    chk("rst_frame", frame, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 48; k++) begin
      chk($sformatf("tv%0d_bin", k), bin, tv[k].bin);
      chk($sformatf("tv%0d_an", k), an, tv[k].an);
      chk($sformatf("tv%0d_frame", k), frame, tv[k].frame);
      if (k == 32) chk("coincident_pflag", dut.pflag, 1'b0);
      ld = tv[k].ld; data = tv[k].data;
      step(1);
    end
    ld = 1'b0;

    // Leading-zero blanking with 16'h0040.
    rst = 1'b1; step(1); rst = 1'b0;
    blank_en = 1'b1;
    ld = 1'b1; data = 16'h0040; step(1); ld = 1'b0;   // now k=1
    step(15);                                          // k=16
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("blank40_s%0d_an", j), an, an_b[j]);
      chk($sformatf("blank40_s%0d_bin", j), bin, bin_b[j]);
      if (j < 3) step(4);
    end
    step(1);                                           // k=29, slot 3
    blank_en = 1'b0; #1;
    chk("blank_off_an", an, 4'b0111);
    chk("blank_off_bin", bin, 4'h0);
    blank_en = 1'b1; #1;
    chk("blank_on_an", an, 4'b1111);
    step(2);                                           // k=31, wrap
    chk("wrap_frame", frame, 1'b1);
    ld = 1'b1; data = 16'h0000; step(1); ld = 1'b0;    // k=32, disp=0
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("blank0_s%0d_an", j), an, an_z[j]);
      step(4);
    end                                                // k=40, slot 2
    chk("blank0_s2_an", an, an_z[2]);

    // Reset mid-slot-2 with a load pending; a coincident LD must be ignored.
    blank_en = 1'b0;
    step(1);
    ld = 1'b1; data = 16'h5678; step(1);               // k=42
    chk("pend_set", dut.pflag, 1'b1);
    rst = 1'b1; ld = 1'b1; data = 16'h9999; step(1);
    rst = 1'b0; ld = 1'b0;
    chk("midrst_an", an, 4'b1110);
    chk("midrst_bin", bin, 4'h0);
    chk("midrst_presc", 32'(dut.presc), 32'd0);
    chk("midrst_pflag", dut.pflag, 1'b0);
    step(3);
    chk("midrst_k3_an", an, 4'b1110);
    step(1);
    chk("midrst_k4_an", an, 4'b1101);
    step(12);                                          // k=16, past wrap
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("midrst_after_s%0d_bin", j), bin, 4'h0);
      step(4);
    end

    // Slot and frame length on the larger divider.
    rst2 = 1'b1; step(1); rst2 = 1'b0;
    cnt = 0;
    while (an2 == 4'b1110 && cnt < 2000) begin
      step(1);
      cnt++;
    end
    chk("slot_len", cnt, 32'd1000);
    cnt = 0;
    while (frame2 !== 1'b1 && cnt < 5000) begin
      step(1);
      cnt++;
    end
    chk("first_frame_at", cnt, 32'd2999);
    step(1);
    chk("frame_one_cycle", frame2, 1'b0);
    cnt = 1;
    while (frame2 !== 1'b1 && cnt < 5000) begin
      step(1);
      cnt++;
    end
    chk("frame_len", cnt, 32'd4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
